// File: rtl/gpio_pkg.sv
// gpio_pkg: constants shared by the GPIO pad controller and its synchronizer.
//   IRQ_MODE_*      : per-bit interrupt mode encoding (irq_mode_i)
//   IRQ_POL_*       : per-bit interrupt polarity encoding (irq_pol_i)
//   SYNC_STAGES_*   : legal bounds for the input synchronizer depth
//   WARM_W          : width of the post-reset warm-up counter
package gpio_pkg;

    localparam logic IRQ_MODE_LEVEL = 1'b0;
    localparam logic IRQ_MODE_EDGE  = 1'b1;

    localparam logic IRQ_POL_LOW    = 1'b0;
    localparam logic IRQ_POL_HIGH   = 1'b1;

    localparam int SYNC_STAGES_MIN  = 2;
    localparam int SYNC_STAGES_MAX  = 4;

    // Must hold SYNC_STAGES_MAX without wrapping.
    localparam int WARM_W           = 3;

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: WIDTH-bit wide, STAGES-deep flop chain bringing asynchronous pad
// levels into the clk_i domain.
//   clk_i   : sampling clock
//   rst_ni  : asynchronous active-low reset, clears every stage
//   d_i     : raw pad values
//   q_o     : synchronized values (last stage of the chain)
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: per-bit GPIO pad driver, input synchronizer and interrupt
// event detector.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   pad_io         : bidirectional pads
//   out_data_i     : value driven on pads whose out_en_i bit is 1
//   out_en_i       : 1 = drive pad, 0 = tristate
//   in_data_o      : synchronized pad values
//   irq_en_i       : per-bit mask applied to irq_o only
//   irq_mode_i     : 0 = level, 1 = edge
//   irq_pol_i      : 1 = rising/high, 0 = falling/low
//   irq_clr_i      : write-1-to-clear pulse for sticky edge status
//   irq_status_o   : raw per-bit status
//   irq_o          : OR of enabled status bits
module gpio_pad_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    inout  wire  [WIDTH-1:0] pad_io,
    input  logic [WIDTH-1:0] out_data_i,
    input  logic [WIDTH-1:0] out_en_i,
    output logic [WIDTH-1:0] in_data_o,
    input  logic [WIDTH-1:0] irq_en_i,
    input  logic [WIDTH-1:0] irq_mode_i,
    input  logic [WIDTH-1:0] irq_pol_i,
    input  logic [WIDTH-1:0] irq_clr_i,
    output logic [WIDTH-1:0] irq_status_o,
    output logic             irq_o
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("gpio_pad_ctrl: SYNC_STAGES out of range");
    end

    logic [WIDTH-1:0]  s_p0;        // synchronized pad value
    logic [WIDTH-1:0]  p_p1;        // s_p0 one cycle earlier
    logic [WIDTH-1:0]  evt;
    logic [WIDTH-1:0]  status_d;
    logic [WIDTH-1:0]  status_q;
    logic [WARM_W-1:0] warm_cnt;
    logic              armed;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign pad_io[i] = out_en_i[i] ? out_data_i[i] : 1'bz;
    end

    // ---- stage p0: pad -> synchronized value ----
    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pad_io),
        .q_o    (s_p0)
    );

    assign in_data_o = s_p0;

    // ---- stage p1: previous value and warm-up ----
    // The chain flushes reset zeros for SYNC_STAGES cycles; holding events off
    // one cycle beyond that keeps a pad that was already high at reset from
    // looking like a rising edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_p1     <= '0;
            warm_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            p_p1 <= s_p0;
            if (!armed) begin
                warm_cnt <= warm_cnt + 1'b1;
                if (warm_cnt == WARM_W'(SYNC_STAGES)) begin
                    armed <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        evt      = '0;
        status_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (irq_mode_i[i] == IRQ_MODE_LEVEL) begin
                evt[i]      = armed & (s_p0[i] == irq_pol_i[i]);
                status_d[i] = evt[i];
            end else begin
                if (irq_pol_i[i] == IRQ_POL_HIGH) begin
                    evt[i] = armed & s_p0[i] & ~p_p1[i];
                end else begin
                    evt[i] = armed & ~s_p0[i] & p_p1[i];
                end
                // A new event outranks a clear arriving in the same cycle.
                status_d[i] = evt[i] | (status_q[i] & ~irq_clr_i[i]);
            end
        end
    end

    // ---- stage p2: interrupt status ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign irq_status_o = status_q;
    assign irq_o        = |(status_q & irq_en_i);

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: directed scenarios plus randomized traffic for
// gpio_pad_ctrl, checked against a reference model built on the history of
// sampled pad values.
module tb_gpio_pad_ctrl;

    localparam int W  = 32;
    localparam int SS = 2;

    logic          clk;
    logic          rst_n;
    wire  [W-1:0]  pad;
    logic [W-1:0]  out_data, out_en, in_data;
    logic [W-1:0]  irq_en, irq_mode, irq_pol, irq_clr, irq_status;
    logic          irq;

    // pad model on the far side of the pads
    logic [W-1:0]  pm_en, pm_val;

    for (genvar i = 0; i < W; i++) begin : g_pm
        assign pad[i] = pm_en[i] ? pm_val[i] : 1'bz;
    end

    gpio_pad_ctrl #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pad_io       (pad),
        .out_data_i   (out_data),
        .out_en_i     (out_en),
        .in_data_o    (in_data),
        .irq_en_i     (irq_en),
        .irq_mode_i   (irq_mode),
        .irq_pol_i    (irq_pol),
        .irq_clr_i    (irq_clr),
        .irq_status_o (irq_status),
        .irq_o        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: hist[k] is the pad value present at the k-th rising
    // edge after reset release; everything before edge 1 reads as 0.
    logic [W-1:0] hist [0:8191];
    int           k;
    logic [W-1:0] m_status;

    function automatic logic [W-1:0] vat(input int idx);
        return (idx <= 0) ? '0 : hist[idx];
    endfunction

    function automatic logic [W-1:0] pad_val();
        return (out_en & out_data) | (~out_en & pm_en & pm_val);
    endfunction

    // One clock with full model comparison. Inputs are changed by callers
    // only after this returns (1 time unit past the edge).
    task automatic tick();
        logic [W-1:0] s_prev, p_prev;
        bit           armed_prev;
        @(posedge clk);
        k++;
        // the synchronized value visible before edge k was sampled SS-1 edges earlier
        s_prev     = vat(k - SS);
        p_prev     = vat(k - SS - 1);
        armed_prev = (k - 1) >= (SS + 1);
        for (int i = 0; i < W; i++) begin
            bit ev;
            if (!armed_prev)
                ev = 1'b0;
            else if (irq_mode[i])
                ev = irq_pol[i] ? (s_prev[i] && !p_prev[i]) : (!s_prev[i] && p_prev[i]);
            else
                ev = (s_prev[i] == irq_pol[i]);
            if (irq_mode[i])
                m_status[i] = ev || (m_status[i] && !irq_clr[i]);
            else
                m_status[i] = ev;
        end
        hist[k] = pad_val();
        #1;
        check("in_data", in_data, vat(k - SS + 1));
        check("irq_status", irq_status, m_status);
        check("irq", 32'(irq), 32'(|(m_status & irq_en)));
    endtask

    // Plain clock without model (used while pads float).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_in_data", in_data, 32'h0);
        check("rst_status", irq_status, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        cyc();
        cyc();
        rst_n    = 1'b1;
        k        = 0;
        m_status = '0;
    endtask

    initial begin
        rst_n    = 1'b0;
        out_data = '0;
        out_en   = '0;
        irq_en   = '0;
        irq_mode = '0;
        irq_pol  = '0;
        irq_clr  = '0;
        pm_en    = '1;
        pm_val   = '0;
        k        = 0;
        m_status = '0;

        // Warm-up: pad 0 high through reset, all rising-edge, all enabled.
        irq_mode = '1;
        irq_pol  = '1;
        irq_en   = '1;
        pm_val   = 32'h1;
        do_reset();
        tick();
        check("sync_lat1", 32'(in_data[0]), 32'h0);
        tick();
        check("sync_in0", 32'(in_data[0]), 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("warm_status", irq_status, 32'h0);
        end

        // Rising edge on bit 3.
        pm_val[3] = 1'b1;
        tick();
        tick();
        check("rise3_early", 32'(irq_status[3]), 32'h0);
        tick();
        check("rise3_status", 32'(irq_status[3]), 32'h1);
        check("rise3_irq", 32'(irq), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rise3_sticky", 32'(irq_status[3]), 32'h1);
        end
        irq_clr = 32'h8;
        tick();
        irq_clr = '0;
        check("rise3_clr", 32'(irq_status[3]), 32'h0);
        check("rise3_clr_irq", 32'(irq), 32'h0);

        // Falling edge on bit 5 coinciding with its clear.
        irq_pol[5] = 1'b0;
        pm_val[5]  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("fall5_norise", 32'(irq_status[5]), 32'h0);
        pm_val[5] = 1'b0;
        tick();
        tick();
        irq_clr[5] = 1'b1;
        tick();
        irq_clr = '0;
        check("fall5_setwins", 32'(irq_status[5]), 32'h1);
        tick();
        irq_clr = 32'h20;
        tick();
        irq_clr = '0;
        check("fall5_clr", 32'(irq_status[5]), 32'h0);

        // Level-low on bit 7 with pad at 0.
        irq_mode[7] = 1'b0;
        irq_pol[7]  = 1'b0;
        tick();
        check("lvl7_set", 32'(irq_status[7]), 32'h1);
        for (int i = 0; i < 2; i++) begin
            irq_clr = 32'h80;
            tick();
            irq_clr = '0;
            check("lvl7_clr_ignored", 32'(irq_status[7]), 32'h1);
        end
        pm_val[7] = 1'b1;
        tick();
        tick();
        check("lvl7_hold", 32'(irq_status[7]), 32'h1);
        tick();
        check("lvl7_drop", 32'(irq_status[7]), 32'h0);

        // Mask: bit 2 edge status with enable off.
        irq_en[2] = 1'b0;
        pm_val[2] = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("mask2_status", 32'(irq_status[2]), 32'h1);
        check("mask2_irq_off", 32'(irq), 32'h0);
        irq_en[2] = 1'b1;
        #1;
        check("mask2_irq_on", 32'(irq), 32'h1);

        // Output drive with the pad model tristated.
        pm_en    = '0;
        out_en   = 32'h0000_00F0;
        out_data = 32'h0000_00A5;
        #1;
        check("drive_pads", 32'(pad[7:4]), 32'hA);
        cyc();
        check("drive_lat1", 32'(in_data[7:4]), 32'h8);
        cyc();
        check("drive_in", 32'(in_data[7:4]), 32'hA);

        // Randomized traffic, with a reset dropped in mid-run.
        out_en   = $urandom;
        out_data = $urandom;
        pm_en    = ~out_en;
        pm_val   = $urandom;
        irq_mode = $urandom;
        irq_pol  = $urandom;
        irq_en   = $urandom;
        irq_clr  = '0;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                irq_mode = $urandom;
                do_reset();
            end
            pm_val   ^= ($urandom & $urandom & $urandom);
            out_data ^= ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) begin
                out_en = $urandom;
                pm_en  = ~out_en;
            end
            irq_clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            if ($urandom_range(0, 31) == 0) irq_pol = $urandom;
            if ($urandom_range(0, 15) == 0) irq_en  = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_pad_ctrl.md
# gpio_pad_ctrl

Device-side pad controller for the GPIO core: drives each pad when its output enable is set, synchronizes pad inputs into the `clk_i` domain, and detects edge- or level-based interrupt events per bit. It sits between the Wishbone register file (which supplies output, enable, interrupt configuration and clear pulses) and the top-level `inout` pads. The bench pad model connects to the same pads from the other side.

## Interface

- Parameters
  - `WIDTH`, 32: number of GPIO bits.
  - `SYNC_STAGES`, 2: input synchronizer depth; legal range 2..4.
- Ports
  - `clk_i` in 1: single clock.
  - `rst_ni` in 1: reset, asynchronous, active-low.
  - `pad_io` inout WIDTH: GPIO pads.
  - `out_data_i` in WIDTH: value to drive.
  - `out_en_i` in WIDTH: 1 = drive pad, 0 = tristate.
  - `in_data_o` out WIDTH: synchronized pad value.
  - `irq_en_i` in WIDTH: per-bit interrupt mask.
  - `irq_mode_i` in WIDTH: 0 = level, 1 = edge.
  - `irq_pol_i` in WIDTH: 1 = rising/high, 0 = falling/low.
  - `irq_clr_i` in WIDTH: write-1-to-clear pulse, one cycle.
  - `irq_status_o` out WIDTH: per-bit raw status, not masked.
  - `irq_o` out 1: `|(irq_status_o & irq_en_i)`.

## Operation

- Pad drive is combinational: `pad_io[i] = out_en_i[i] ? out_data_i[i] : 'z`. With the output enabled, `in_data_o` reads back the driven pad value through the synchronizer.
- Synchronizer: a `SYNC_STAGES`-deep flop chain per bit. `s` is the last stage. `in_data_o = s`.
- Previous-value register `p` is loaded from `s` every cycle.
- Warm-up counter:
  - After reset it counts `SYNC_STAGES+1` cycles. Then `armed` = 1.
  - No status bit may be set while `armed` = 0. This prevents spurious edges when pads are high at reset.
- Event per bit while `armed`:
  - Edge mode, pol = 1: `s & ~p`.
  - Edge mode, pol = 0: `~s & p`.
  - Level mode: `s == pol`.
- Status update per bit, registered:
  - Edge mode: sticky. Set on event, cleared by `irq_clr_i`. If set and clear occur in the same cycle, set wins.
  - Level mode: status = event each cycle. `irq_clr_i` has no lasting effect while the level persists.
- Status sets regardless of `irq_en_i`; only `irq_o` is masked.
- Mode or polarity change mid-operation: takes effect on the next cycle. Existing edge status is retained until cleared.
- `irq_o` is combinational from status and mask. It needs no extra register.

## Timing

- Reset values:
  - Synchronizer, `p`, status and warm-up counter = 0.
  - `armed` = 0.
  - `in_data_o` = 0, `irq_status_o` = 0, `irq_o` = 0.
- Pad drive: 0 cycles from `out_en_i`/`out_data_i`.
- Input latency: a pad change sampled at edge 0 appears on `in_data_o` after `SYNC_STAGES` rising edges.
- Edge status: set at edge `SYNC_STAGES+1`, with `irq_o` on the same cycle.
- Clear: `irq_clr_i` high at edge k gives status 0 after edge k, unless a new event occurs at k.
- Pulses shorter than one clock period may be missed; this is not an error.
- Reset assertion mid-operation: all state clears immediately, asynchronously. Warm-up restarts after deassertion.

## Structure

- Shared package `gpio_pkg` holds:
  - `IRQ_MODE_LEVEL`/`IRQ_MODE_EDGE` and `IRQ_POL_LOW`/`IRQ_POL_HIGH` constants.
  - The `SYNC_STAGES` legality bounds.
- Sub-module `gpio_sync`: a parameterized `WIDTH`×`SYNC_STAGES` synchronizer with async active-low reset. The top instantiates it once.
- Warm-up counter, edge detect and status logic live in the top module.

## Test plan

- Reset release with pad bit 0 held at 1 by the pad model, all bits in rising-edge mode with enables on:
  - `irq_status_o` stays 0 through warm-up.
  - `in_data_o[0]` = 1 after 2 cycles.
- Pad bit 3 toggles 0→1 in rising-edge mode with `irq_en_i[3]=1`:
  - `irq_status_o[3]` and `irq_o` are 1 exactly 3 cycles after sampling.
  - They stay 1 until `irq_clr_i=8`.
- Same-cycle event and clear: a falling edge on bit 5 coincides with `irq_clr_i[5]=1` → status remains 1.
- Level-low mode on bit 7 with the pad held at 0:
  - Status stays 1 despite clear pulses.
  - Pad driven to 1 → status 0 after 3 cycles.
- Output drive: `out_en_i=0x0000_00F0`, `out_data_i=0xA5`, model tristated:
  - Pads [7:4] read 0xA.
  - Others read z.
  - `in_data_o[7:4]` = 0xA after 2 cycles.
- Mask: bit 2 edge set with `irq_en_i[2]=0` → `irq_status_o[2]=1`, `irq_o=0`. Then enabling the bit raises `irq_o` in the same cycle.
